ibex_cosim_retire_ctrl: RTL and testbench

- Sequences lockstep comparison of Ibex retirement records (RVFI) against an external reference-model record stream.
- Buffers retired instructions in a FIFO and pops one record per reference handshake.
- Compares fields, records the first mismatch and throttles fetch when the buffer nears full.
- Sits beside ibex_top in the tracing top level; replaces file-based post-run compare with in-sim checking.

---
 rtl/ibex_cosim_retire_ctrl_if.sv | 55 +++++
 rtl/ibex_cosim_retire_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ibex_cosim_retire_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_cosim_retire_ctrl_if.sv
// Retirement (RVFI) and reference-model record bundle for ibex_cosim_retire_ctrl.
// Memory fields are present only when IBEX_COSIM_MEM_CHECK_EN is defined.
interface ibex_cosim_retire_ctrl_if;
   logic        rvfi_valid_i;
   logic [31:0] rvfi_pc_rdata_i;
   logic [31:0] rvfi_insn_i;
   logic [4:0]  rvfi_rd_addr_i;
   logic [31:0] rvfi_rd_wdata_i;
   logic        rvfi_trap_i;
   logic        ref_valid_i;
   logic        ref_ready_o;
   logic [31:0] ref_pc_i;
   logic [31:0] ref_insn_i;
   logic [4:0]  ref_rd_addr_i;
   logic [31:0] ref_rd_wdata_i;
   logic        ref_trap_i;
`ifdef IBEX_COSIM_MEM_CHECK_EN
   logic [31:0] rvfi_mem_addr_i;
   logic [3:0]  rvfi_mem_wmask_i;
   logic [31:0] rvfi_mem_wdata_i;
   logic [31:0] ref_mem_addr_i;
   logic [3:0]  ref_mem_wmask_i;
   logic [31:0] ref_mem_wdata_i;

   modport master (
      output rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
             rvfi_trap_i, ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i,
             ref_rd_wdata_i, ref_trap_i, rvfi_mem_addr_i, rvfi_mem_wmask_i,
             rvfi_mem_wdata_i, ref_mem_addr_i, ref_mem_wmask_i, ref_mem_wdata_i,
      input  ref_ready_o
   );

   modport slave (
      input  rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
             rvfi_trap_i, ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i,
             ref_rd_wdata_i, ref_trap_i, rvfi_mem_addr_i, rvfi_mem_wmask_i,
             rvfi_mem_wdata_i, ref_mem_addr_i, ref_mem_wmask_i, ref_mem_wdata_i,
      output ref_ready_o
   );
`else
   modport master (
      output rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
             rvfi_trap_i, ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i,
             ref_rd_wdata_i, ref_trap_i,
      input  ref_ready_o
   );

   modport slave (
      input  rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
             rvfi_trap_i, ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i,
             ref_rd_wdata_i, ref_trap_i,
      output ref_ready_o
   );
`endif
endinterface

// File: rtl/ibex_cosim_retire_ctrl.sv
// Lockstep checker: buffers Ibex RVFI retirements and compares them against a reference stream.
// Optional memory-field compare is enabled by defining IBEX_COSIM_MEM_CHECK_EN.
module ibex_cosim_retire_ctrl #(
   parameter int unsigned FifoDepth   = 8,
   parameter int unsigned StallMargin = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic                    clear_i,
   ibex_cosim_retire_ctrl_if.slave rec,
   output logic                    fetch_stall_o,
   output logic                    mismatch_o,
   output logic [4:0]              mismatch_mask_o,
   output logic [31:0]             mismatch_pc_o,
   output logic                    overflow_o,
   output logic [31:0]             match_cnt_o
);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {IDLE, RUN, HALT, OVF} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
`ifdef IBEX_COSIM_MEM_CHECK_EN
      logic [31:0] mem_addr;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_wdata;
`endif
   } entry_t;

   state_e          state_q;
   entry_t          mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d, free_d;
   logic            fetch_stall_q, mismatch_q, overflow_q;
   logic [4:0]      mismatch_mask_q;
   logic [31:0]     mismatch_pc_q, match_cnt_q;

   entry_t     wr_entry, head;
   logic       ref_ready_c, clear_fire, push_ok, full, pop, wr_en;
   logic       ovf_evt, mis_evt, match_evt, halt_or_ovf_d;
   logic [4:0] diff;
`ifdef IBEX_COSIM_MEM_CHECK_EN
   logic [31:0] byte_mask;
`endif

   // Handshake, FIFO bookkeeping and field compare of the head entry
   always_comb begin
      wr_entry          = '0;
      wr_entry.pc       = rec.rvfi_pc_rdata_i;
      wr_entry.insn     = rec.rvfi_insn_i;
      wr_entry.rd_addr  = rec.rvfi_rd_addr_i;
      wr_entry.rd_wdata = rec.rvfi_rd_wdata_i;
      wr_entry.trap     = rec.rvfi_trap_i;
`ifdef IBEX_COSIM_MEM_CHECK_EN
      wr_entry.mem_addr  = rec.rvfi_mem_addr_i;
      wr_entry.mem_wmask = rec.rvfi_mem_wmask_i;
      wr_entry.mem_wdata = rec.rvfi_mem_wdata_i;
`endif
      head        = mem_q[rd_ptr_q];
      ref_ready_c = (state_q == RUN) && (count_q != '0);
      clear_fire  = clear_i && ((state_q == HALT) || (state_q == OVF));
      push_ok     = rec.rvfi_valid_i && ((state_q == RUN) || (state_q == HALT)) && !clear_fire;
      full        = (count_q == CntW'(FifoDepth));
      pop         = rec.ref_valid_i && ref_ready_c;
      wr_en       = push_ok && (!full || pop);
      ovf_evt     = push_ok && full && !pop;

      diff    = '0;
      diff[0] = (head.pc != rec.ref_pc_i);
      diff[1] = (head.insn != rec.ref_insn_i);
      // rd write data is meaningless when the destination is x0
      diff[2] = (head.rd_addr != rec.ref_rd_addr_i) ||
                ((head.rd_addr != 5'd0) && (head.rd_wdata != rec.ref_rd_wdata_i));
      diff[3] = (head.trap != rec.ref_trap_i);
`ifdef IBEX_COSIM_MEM_CHECK_EN
      byte_mask = {{8{rec.ref_mem_wmask_i[3]}}, {8{rec.ref_mem_wmask_i[2]}},
                   {8{rec.ref_mem_wmask_i[1]}}, {8{rec.ref_mem_wmask_i[0]}}};
      diff[4]   = (head.mem_wmask != rec.ref_mem_wmask_i) ||
                  ((rec.ref_mem_wmask_i != 4'd0) &&
                   ((head.mem_addr != rec.ref_mem_addr_i) ||
                    (((head.mem_wdata ^ rec.ref_mem_wdata_i) & byte_mask) != 32'd0)));
`endif
      mis_evt   = pop && (diff != 5'd0);
      match_evt = pop && (diff == 5'd0);

      count_d = clear_fire ? '0 : (count_q + CntW'(wr_en) - CntW'(pop));
      free_d  = CntW'(FifoDepth) - count_d;
      halt_or_ovf_d = (((state_q == HALT) || (state_q == OVF)) && !clear_fire) ||
                      mis_evt || ovf_evt;
   end

   // Control state, pointers and registered status
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         fetch_stall_q   <= 1'b0;
         mismatch_q      <= 1'b0;
         mismatch_mask_q <= '0;
         mismatch_pc_q   <= '0;
         overflow_q      <= 1'b0;
         match_cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (enable_i) state_q <= RUN;
            RUN: begin
               if (ovf_evt)      state_q <= OVF;
               else if (mis_evt) state_q <= HALT;
            end
            HALT: begin
               if (clear_i)      state_q <= RUN;
               else if (ovf_evt) state_q <= OVF;
            end
            OVF:  if (clear_i) state_q <= RUN;
            default: state_q <= IDLE;
         endcase

         count_q <= count_d;
         if (clear_fire) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end

         fetch_stall_q <= halt_or_ovf_d || (free_d <= CntW'(StallMargin));

         if (clear_fire) begin
            mismatch_q      <= 1'b0;
            mismatch_mask_q <= '0;
            mismatch_pc_q   <= '0;
            overflow_q      <= 1'b0;
         end else begin
            if (mis_evt && !mismatch_q) begin
               mismatch_q      <= 1'b1;
               mismatch_mask_q <= diff;
               mismatch_pc_q   <= head.pc;
            end
            if (ovf_evt) overflow_q <= 1'b1;
         end

         if (match_evt && (match_cnt_q != 32'hFFFF_FFFF)) match_cnt_q <= match_cnt_q + 32'd1;
      end
   end

   // Entry storage; validity is tracked solely by the pointers
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign rec.ref_ready_o   = ref_ready_c;
   assign fetch_stall_o     = fetch_stall_q;
   assign mismatch_o        = mismatch_q;
   assign mismatch_mask_o   = mismatch_mask_q;
   assign mismatch_pc_o     = mismatch_pc_q;
   assign overflow_o        = overflow_q;
   assign match_cnt_o       = match_cnt_q;
endmodule

// File: tb/tb_ibex_cosim_retire_ctrl.sv
// Directed scoreboard bench for ibex_cosim_retire_ctrl (FifoDepth=8, StallMargin=2).
module tb_ibex_cosim_retire_ctrl;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
   } rec_t;

   typedef struct {
      logic [4:0]  mask;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        fetch_stall, mismatch, overflow;
   logic [4:0]  mismatch_mask;
   logic [31:0] mismatch_pc, match_cnt;

   ibex_cosim_retire_ctrl_if bus ();

   ibex_cosim_retire_ctrl #(.FifoDepth(8), .StallMargin(2)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .enable_i       (enable),
      .clear_i        (clear),
      .rec            (bus),
      .fetch_stall_o  (fetch_stall),
      .mismatch_o     (mismatch),
      .mismatch_mask_o(mismatch_mask),
      .mismatch_pc_o  (mismatch_pc),
      .overflow_o     (overflow),
      .match_cnt_o    (match_cnt)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   passed = 0;
   rec_t core_q[$];
   exp_t exp_q[$];
   logic        exp_mis = 1'b0;
   logic [4:0]  exp_mask = '0;
   logic [31:0] exp_pc = '0;
   logic [31:0] exp_cnt = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic rec_t mk(input int i);
      rec_t r;
      r.pc       = 32'h8000_0000 + 32'(i * 4);
      r.insn     = 32'h0000_0013 | (32'(i) << 7);
      r.rd_addr  = 5'((i % 31) + 1);
      r.rd_wdata = 32'(i * 3 + 7);
      r.trap     = 1'b0;
      return r;
   endfunction

   function automatic logic [4:0] model_mask(input rec_t c, input rec_t r);
      logic [4:0] m;
      m    = 5'd0;
      m[0] = c.pc !== r.pc;
      m[1] = c.insn !== r.insn;
      m[2] = (c.rd_addr !== r.rd_addr) || ((c.rd_addr != 5'd0) && (c.rd_wdata !== r.rd_wdata));
      m[3] = c.trap !== r.trap;
      return m;
   endfunction

   task automatic drive_rvfi(input rec_t r);
      bus.rvfi_valid_i    = 1'b1;
      bus.rvfi_pc_rdata_i = r.pc;
      bus.rvfi_insn_i     = r.insn;
      bus.rvfi_rd_addr_i  = r.rd_addr;
      bus.rvfi_rd_wdata_i = r.rd_wdata;
      bus.rvfi_trap_i     = r.trap;
   endtask

   task automatic drive_ref(input rec_t r);
      bus.ref_valid_i    = 1'b1;
      bus.ref_pc_i       = r.pc;
      bus.ref_insn_i     = r.insn;
      bus.ref_rd_addr_i  = r.rd_addr;
      bus.ref_rd_wdata_i = r.rd_wdata;
      bus.ref_trap_i     = r.trap;
   endtask

   task automatic push(input rec_t r, input bit accepted);
      drive_rvfi(r);
      if (accepted) core_q.push_back(r);
      tick();
      bus.rvfi_valid_i = 1'b0;
   endtask

   // Scoreboard side: model the compare of the head against the reference record
   task automatic expect_pop(input rec_t r);
      rec_t c;
      exp_t e;
      if (core_q.size() == 0) begin
         check("model_queue_nonempty", 32'(core_q.size()), 32'd1);
         return;
      end
      c = core_q.pop_front();
      e.mask = model_mask(c, r);
      e.pc   = c.pc;
      exp_q.push_back(e);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask == 5'd0) begin
         if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      end else if (!exp_mis) begin
         exp_mis  = 1'b1;
         exp_mask = e.mask;
         exp_pc   = e.pc;
      end
      check({tag, "_mismatch"}, 32'(mismatch), 32'(exp_mis));
      check({tag, "_mask"}, 32'(mismatch_mask), 32'(exp_mask));
      check({tag, "_pc"}, mismatch_pc, exp_pc);
      check({tag, "_cnt"}, match_cnt, exp_cnt);
   endtask

   task automatic pop(input rec_t r, input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ref_ready_o === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) begin
         check({tag, "_ready_timeout"}, 32'(bus.ref_ready_o), 32'd1);
         return;
      end
      drive_ref(r);
      expect_pop(r);
      tick();
      bus.ref_valid_i = 1'b0;
      check_result(tag);
   endtask

   task automatic pop_head(input string tag);
      rec_t r;
      r = core_q[0];
      pop(r, tag);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      core_q.delete();
      exp_mis  = 1'b0;
      exp_mask = '0;
      exp_pc   = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, 32'(fetch_stall), 32'd0);
      check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
      check({tag, "_mask"}, 32'(mismatch_mask), 32'd0);
      check({tag, "_pc"}, mismatch_pc, 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_cnt"}, match_cnt, 32'd0);
      check({tag, "_ready"}, 32'(bus.ref_ready_o), 32'd0);
   endtask

   initial begin
      rec_t r;
      bus.rvfi_valid_i = 1'b0; bus.rvfi_pc_rdata_i = '0; bus.rvfi_insn_i = '0;
      bus.rvfi_rd_addr_i = '0; bus.rvfi_rd_wdata_i = '0; bus.rvfi_trap_i = 1'b0;
      bus.ref_valid_i = 1'b0; bus.ref_pc_i = '0; bus.ref_insn_i = '0;
      bus.ref_rd_addr_i = '0; bus.ref_rd_wdata_i = '0; bus.ref_trap_i = 1'b0;
`ifdef IBEX_COSIM_MEM_CHECK_EN
      bus.rvfi_mem_addr_i = '0; bus.rvfi_mem_wmask_i = '0; bus.rvfi_mem_wdata_i = '0;
      bus.ref_mem_addr_i = '0; bus.ref_mem_wmask_i = '0; bus.ref_mem_wdata_i = '0;
`endif
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Retirements before enable are ignored
      push(mk(99), 1'b0);
      check("idle_ignored_ready", 32'(bus.ref_ready_o), 32'd0);
      enable = 1'b1;
      tick();
      enable = 1'b0;

      // Matching stream of four records
      for (int i = 0; i < 4; i++) push(mk(i), 1'b1);
      check("match_stall", 32'(fetch_stall), 32'd0);
      for (int i = 0; i < 4; i++) pop(mk(i), "match");
      check("match_empty_ready", 32'(bus.ref_ready_o), 32'd0);

      // Second record differs in rd write data with rd=3
      r = mk(10); r.rd_addr = 5'd3; r.rd_wdata = 32'h6;
      push(mk(9), 1'b1);
      push(r, 1'b1);
      pop(mk(9), "mis_first");
      r.rd_wdata = 32'h5;
      pop(r, "mis_second");
      check("mis_stall", 32'(fetch_stall), 32'd1);
      check("mis_ready_halt", 32'(bus.ref_ready_o), 32'd0);
      pulse_clear();
      check("clr_mismatch", 32'(mismatch), 32'd0);
      check("clr_mask", 32'(mismatch_mask), 32'd0);
      check("clr_pc", mismatch_pc, 32'd0);
      check("clr_stall", 32'(fetch_stall), 32'd0);
      check("clr_cnt", match_cnt, exp_cnt);

      // Destination x0: write data is not compared
      r = mk(20); r.rd_addr = 5'd0; r.rd_wdata = 32'hDEAD;
      push(r, 1'b1);
      r.rd_wdata = 32'hBEEF;
      pop(r, "rd0");

      // Stall threshold
      for (int i = 0; i < 5; i++) push(mk(30 + i), 1'b1);
      check("stall_5", 32'(fetch_stall), 32'd0);
      push(mk(35), 1'b1);
      check("stall_6", 32'(fetch_stall), 32'd1);
      pop_head("stall_pop");
      check("stall_release", 32'(fetch_stall), 32'd0);
      while (core_q.size() > 0) pop_head("stall_drain");

      // Overflow on a push into a full buffer with no pop
      for (int i = 0; i < 8; i++) push(mk(40 + i), 1'b1);
      check("full_ready", 32'(bus.ref_ready_o), 32'd1);
      push(mk(48), 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_ready", 32'(bus.ref_ready_o), 32'd0);
      check("ovf_stall", 32'(fetch_stall), 32'd1);
      pulse_clear();
      check("ovf_clr_flag", 32'(overflow), 32'd0);
      check("ovf_clr_ready", 32'(bus.ref_ready_o), 32'd0);
      check("ovf_clr_cnt", match_cnt, exp_cnt);

      // Simultaneous push and pop on a full buffer
      for (int i = 0; i < 8; i++) push(mk(50 + i), 1'b1);
      drive_rvfi(mk(58));
      drive_ref(core_q[0]);
      expect_pop(core_q[0]);
      core_q.push_back(mk(58));
      tick();
      bus.rvfi_valid_i = 1'b0;
      bus.ref_valid_i  = 1'b0;
      check_result("pushpop");
      check("pushpop_ovf", 32'(overflow), 32'd0);
      check("pushpop_stall", 32'(fetch_stall), 32'd1);
      while (core_q.size() > 0) pop_head("pushpop_drain");
      check("pushpop_end_ovf", 32'(overflow), 32'd0);

      // Asynchronous reset with entries queued
      for (int i = 0; i < 3; i++) push(mk(60 + i), 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      core_q.delete();
      exp_cnt = '0;
      exp_mis = 1'b0; exp_mask = '0; exp_pc = '0;
      tick();
      rst_n = 1'b1;
      tick();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      check("rearm_ready", 32'(bus.ref_ready_o), 32'd0);
      push(mk(70), 1'b1);
      pop(mk(70), "rearm");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end
endmodule
